datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 23 ++
 rtl/datapath_alu.sv | 63 ++++++
 rtl/datapath.sv | 104 ++++++++++
 tb/tb_datapath.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared word width and ALU opcode encodings for the datapath slice.
package datapath_pkg;

  localparam int WORD = 32;

  typedef enum logic [4:0] {
    ADD  = 5'd3,
    SUB  = 5'd4,
    SHR  = 5'd5,
    SHRA = 5'd6,
    SHL  = 5'd7,
    ROR  = 5'd8,
    ROL  = 5'd9,
    AND  = 5'd10,
    OR   = 5'd11,
    MUL  = 5'd15,
    DIV  = 5'd16,
    NEG  = 5'd17,
    NOT  = 5'd18,
    SHLA = 5'd19
  } opcode_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A from Y, B from the bus, 64-bit result C.
module alu
  import datapath_pkg::*;
(
  input  logic [WORD-1:0]   a,
  input  logic [WORD-1:0]   b,
  input  logic              inc_pc,
  input  logic [4:0]        opcode,
  output logic [2*WORD-1:0] c
);

  logic [4:0]        sh;
  logic [2*WORD-1:0] rot_r;
  logic [2*WORD-1:0] rot_l;
  logic [2*WORD-1:0] a_ext;
  logic [2*WORD-1:0] b_ext;
  logic [2*WORD-1:0] prod;
  logic [WORD-1:0]   quot;
  logic [WORD-1:0]   rem;

  assign sh    = b[4:0];
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;
  assign a_ext = {{WORD{a[WORD-1]}}, a};
  assign b_ext = {{WORD{b[WORD-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Divider is only evaluated with a nonzero divisor so it never yields X.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b != '0) begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end

  always_comb begin
    c = '0;
    if (inc_pc) begin
      c = {{WORD{1'b0}}, b + 32'd1};
    end else begin
      case (opcode_e'(opcode))
        ADD:  c = {{WORD{1'b0}}, a + b};
        SUB:  c = {{WORD{1'b0}}, a - b};
        SHR:  c = {{WORD{1'b0}}, a >> sh};
        SHRA: c = {{WORD{1'b0}}, $signed(a) >>> sh};
        SHL:  c = {{WORD{1'b0}}, a << sh};
        SHLA: c = {{WORD{1'b0}}, a << sh};
        ROR:  c = {{WORD{1'b0}}, rot_r[WORD-1:0]};
        ROL:  c = {{WORD{1'b0}}, rot_l[2*WORD-1:WORD]};
        AND:  c = {{WORD{1'b0}}, a & b};
        OR:   c = {{WORD{1'b0}}, a | b};
        NEG:  c = {{WORD{1'b0}}, -b};
        NOT:  c = {{WORD{1'b0}}, ~b};
        MUL:  c = prod;
        DIV:  c = {rem, quot};
        default: c = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Register file, internal bus mux and falling-edge register loads around the ALU.
module datapath
  import datapath_pkg::*;
(
  input logic            clock,
  input logic            clear,
  input logic [WORD-1:0] Mdatain,
  input logic            MDRread,
  input logic            PCin,
  input logic            PCout,
  input logic            IncPC,
  input logic            MARin,
  input logic            MARout,
  input logic            MDRin,
  input logic            MDRout,
  input logic            IRin,
  input logic            IRout,
  input logic            RYin,
  input logic            RYout,
  input logic            RZinHi,
  input logic            RZinLo,
  input logic            RZoutHi,
  input logic            RZoutLo,
  input logic            LOin,
  input logic            HIin,
  input logic            R2in,
  input logic            R3in,
  input logic            R4in,
  input logic            R5in,
  input logic            R6in,
  input logic            R7in,
  input logic            R2out,
  input logic            R3out,
  input logic            R4out,
  input logic            R5out,
  input logic            R6out,
  input logic            R7out
);

  logic [WORD-1:0]   pc, mar, mdr, ir, y, z_hi, z_lo, hi, lo;
  logic [WORD-1:0]   r [2:7];
  logic [WORD-1:0]   bus;
  logic [2*WORD-1:0] c;
  logic [7:2]        r_in;
  logic [7:2]        r_out;

  assign r_in  = {R7in, R6in, R5in, R4in, R3in, R2in};
  assign r_out = {R7out, R6out, R5out, R4out, R3out, R2out};

  // Priority chain; among R2..R7 the lowest index wins, so scan downward.
  always_comb begin
    bus = '0;
    if (PCout)        bus = pc;
    else if (MDRout)  bus = mdr;
    else if (RZoutLo) bus = z_lo;
    else if (RZoutHi) bus = z_hi;
    else if (RYout)   bus = y;
    else if (IRout)   bus = ir;
    else if (MARout)  bus = mar;
    else begin
      for (int i = 7; i >= 2; i--) begin
        if (r_out[i]) bus = r[i];
      end
    end
  end

  alu u_alu (
    .a      (y),
    .b      (bus),
    .inc_pc (IncPC),
    .opcode (ir[31:27]),
    .c      (c)
  );

  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      pc   <= '0;
      mar  <= '0;
      mdr  <= '0;
      ir   <= '0;
      y    <= '0;
      z_hi <= '0;
      z_lo <= '0;
      hi   <= '0;
      lo   <= '0;
      for (int i = 2; i <= 7; i++) r[i] <= '0;
    end else begin
      if (PCin)       pc <= bus;
      else if (IncPC) pc <= pc + 32'd1;
      if (MARin)  mar  <= bus;
      if (MDRin)  mdr  <= MDRread ? Mdatain : bus;
      if (IRin)   ir   <= bus;
      if (RYin)   y    <= bus;
      if (RZinHi) z_hi <= c[2*WORD-1:WORD];
      if (RZinLo) z_lo <= c[WORD-1:0];
      if (HIin)   hi   <= bus;
      if (LOin)   lo   <= bus;
      for (int i = 2; i <= 7; i++) begin
        if (r_in[i]) r[i] <= bus;
      end
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: ALU vector table plus hand-written register sequences.
module tb_datapath;

  logic        clock = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] Mdatain;
  logic MDRread, PCin, PCout, IncPC, MARin, MARout, MDRin, MDRout, IRin, IRout;
  logic RYin, RYout, RZinHi, RZinLo, RZoutHi, RZoutLo, LOin, HIin;
  logic R2in, R3in, R4in, R5in, R6in, R7in, R2out, R3out, R4out, R5out, R6out, R7out;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] mdata;
    logic mdr_read, pc_in, pc_out, inc_pc, mar_in, mar_out, mdr_in, mdr_out;
    logic ir_in, ir_out, y_in, y_out, z_in_hi, z_in_lo, z_out_hi, z_out_lo;
    logic lo_in, hi_in;
    logic [7:2] r_in;
    logic [7:2] r_out;
  } ctl_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } alu_vec_t;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .MDRread(MDRread),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .MARout(MARout),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .IRout(IRout),
    .RYin(RYin), .RYout(RYout), .RZinHi(RZinHi), .RZinLo(RZinLo),
    .RZoutHi(RZoutHi), .RZoutLo(RZoutLo), .LOin(LOin), .HIin(HIin),
    .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
    .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out)
  );

  always #5 clock = ~clock;

  task automatic drive(input ctl_t c);
    Mdatain = c.mdata;   MDRread = c.mdr_read;
    PCin    = c.pc_in;   PCout   = c.pc_out;  IncPC  = c.inc_pc;
    MARin   = c.mar_in;  MARout  = c.mar_out;
    MDRin   = c.mdr_in;  MDRout  = c.mdr_out;
    IRin    = c.ir_in;   IRout   = c.ir_out;
    RYin    = c.y_in;    RYout   = c.y_out;
    RZinHi  = c.z_in_hi; RZinLo  = c.z_in_lo;
    RZoutHi = c.z_out_hi; RZoutLo = c.z_out_lo;
    LOin    = c.lo_in;   HIin    = c.hi_in;
    {R7in, R6in, R5in, R4in, R3in, R2in}       = c.r_in;
    {R7out, R6out, R5out, R4out, R3out, R2out} = c.r_out;
  endtask

  // Strobes change just after the rising edge; results sampled just after the falling edge.
  task automatic cycle(input ctl_t c);
    @(posedge clock);
    #1 drive(c);
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pc"},   dut.pc,   32'h0);
    check({tag, " mar"},  dut.mar,  32'h0);
    check({tag, " mdr"},  dut.mdr,  32'h0);
    check({tag, " ir"},   dut.ir,   32'h0);
    check({tag, " y"},    dut.y,    32'h0);
    check({tag, " z_hi"}, dut.z_hi, 32'h0);
    check({tag, " z_lo"}, dut.z_lo, 32'h0);
    check({tag, " hi"},   dut.hi,   32'h0);
    check({tag, " lo"},   dut.lo,   32'h0);
    for (int i = 2; i <= 7; i++) check($sformatf("%s r%0d", tag, i), dut.r[i], 32'h0);
  endtask

  // Load a word into MDR from memory, then copy it to the selected destination(s).
  task automatic mem_to_mdr(input logic [31:0] val);
    ctl_t c;
    c = '0; c.mdata = val; c.mdr_read = 1'b1; c.mdr_in = 1'b1;
    cycle(c);
  endtask

  task automatic load_ir(input logic [31:0] val);
    ctl_t c;
    mem_to_mdr(val);
    c = '0; c.mdr_out = 1'b1; c.ir_in = 1'b1;
    cycle(c);
  endtask

  task automatic load_y(input logic [31:0] val);
    ctl_t c;
    mem_to_mdr(val);
    c = '0; c.mdr_out = 1'b1; c.y_in = 1'b1;
    cycle(c);
  endtask

  task automatic load_r(input int idx, input logic [31:0] val);
    ctl_t c;
    mem_to_mdr(val);
    c = '0; c.mdr_out = 1'b1; c.r_in[idx] = 1'b1;
    cycle(c);
  endtask

  alu_vec_t vecs[$];

  initial begin
    ctl_t c;
    drive('0);

    vecs.push_back('{"add",       5'd3,  32'd5,        32'd7,        32'h0,        32'h0000000C});
    vecs.push_back('{"add wrap",  5'd3,  32'hFFFFFFFF, 32'd2,        32'h0,        32'h00000001});
    vecs.push_back('{"sub",       5'd4,  32'd3,        32'd5,        32'h0,        32'hFFFFFFFE});
    vecs.push_back('{"shr",       5'd5,  32'h80000000, 32'd4,        32'h0,        32'h08000000});
    vecs.push_back('{"shra",      5'd6,  32'h80000000, 32'd4,        32'h0,        32'hF8000000});
    vecs.push_back('{"shl mask",  5'd7,  32'h00000001, 32'h0000003F, 32'h0,        32'h80000000});
    vecs.push_back('{"ror",       5'd8,  32'h00000001, 32'd1,        32'h0,        32'h80000000});
    vecs.push_back('{"ror 0",     5'd8,  32'h12345678, 32'd0,        32'h0,        32'h12345678});
    vecs.push_back('{"rol",       5'd9,  32'h80000000, 32'd1,        32'h0,        32'h00000001});
    vecs.push_back('{"and",       5'd10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000});
    vecs.push_back('{"or",        5'd11, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hFFF0FFF0});
    vecs.push_back('{"neg",       5'd17, 32'd5,        32'd1,        32'h0,        32'hFFFFFFFF});
    vecs.push_back('{"not",       5'd18, 32'd5,        32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0});
    vecs.push_back('{"mul neg",   5'd15, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{"mul big",   5'd15, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    vecs.push_back('{"div neg",   5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div",       5'd16, 32'd100,      32'd7,        32'h00000002, 32'h0000000E});
    vecs.push_back('{"div zero",  5'd16, 32'd7,        32'd0,        32'h0,        32'h0});
    vecs.push_back('{"op 0",      5'd0,  32'd5,        32'd6,        32'h0,        32'h0});
    vecs.push_back('{"op 12",     5'd12, 32'd5,        32'd6,        32'h0,        32'h0});

    #2 clear = 1'b1;
    #1 check_all_zero("reset");
    @(posedge clock);
    #1 clear = 1'b0;

    // Memory load into MDR, then MDR to R3.
    mem_to_mdr(32'hFF211111);
    check("mdr load", dut.mdr, 32'hFF211111);
    c = '0; c.mdr_out = 1'b1; c.r_in[3] = 1'b1;
    cycle(c);
    check("r3 load", dut.r[3], 32'hFF211111);

    // Fetch step from PC=0.
    c = '0; c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in_lo = 1'b1;
    cycle(c);
    check("fetch mar", dut.mar, 32'h0);
    check("fetch zlo", dut.z_lo, 32'h1);
    check("fetch pc",  dut.pc,  32'h1);

    // PCin beats IncPC and latches the pre-edge bus value (PC itself).
    c = '0; c.pc_out = 1'b1; c.pc_in = 1'b1; c.inc_pc = 1'b1;
    cycle(c);
    check("pc self load", dut.pc, 32'h1);

    // shla through Y and Z.
    load_r(7, 32'h0000000B);
    load_ir(32'h9A2B8000);
    c = '0; c.r_out[3] = 1'b1; c.y_in = 1'b1;
    cycle(c);
    c = '0; c.r_out[7] = 1'b1; c.z_in_lo = 1'b1;
    cycle(c);
    c = '0; c.z_out_lo = 1'b1; c.r_in[4] = 1'b1;
    cycle(c);
    check("shla r4", dut.r[4], 32'h08888800);

    // Bus priority: PC over MDR; no strobe gives zero.
    c = '0; c.pc_out = 1'b1; c.mdr_out = 1'b1; c.r_out[2] = 1'b1; c.r_in[5] = 1'b1;
    cycle(c);
    check("prio pc", dut.r[5], 32'h1);
    c = '0; c.r_out[7] = 1'b1; c.r_out[3] = 1'b1; c.r_in[2] = 1'b1;
    cycle(c);
    check("prio r3", dut.r[2], 32'hFF211111);
    c = '0; c.r_in[6] = 1'b1;
    cycle(c);
    check("idle bus", dut.r[6], 32'h0);

    // HI/LO load from bus.
    c = '0; c.r_out[7] = 1'b1; c.hi_in = 1'b1; c.lo_in = 1'b1;
    cycle(c);
    check("hi load", dut.hi, 32'hB);
    check("lo load", dut.lo, 32'hB);

    // IncPC overrides opcode: ZLo = bus+1, ZHi = 0.
    c = '0; c.r_out[3] = 1'b1; c.inc_pc = 1'b1; c.z_in_lo = 1'b1; c.z_in_hi = 1'b1;
    cycle(c);
    check("incpc zlo", dut.z_lo, 32'hFF211112);
    check("incpc zhi", dut.z_hi, 32'h0);
    check("incpc pc",  dut.pc,   32'h2);

    foreach (vecs[i]) begin
      load_ir({vecs[i].op, 27'h0});
      load_y(vecs[i].a);
      mem_to_mdr(vecs[i].b);
      c = '0; c.mdr_out = 1'b1; c.z_in_hi = 1'b1; c.z_in_lo = 1'b1;
      cycle(c);
      check({vecs[i].name, " zhi"}, dut.z_hi, vecs[i].exp_hi);
      check({vecs[i].name, " zlo"}, dut.z_lo, vecs[i].exp_lo);
    end

    // Clear mid-operation: immediate zero, no loads while held, resume after release.
    @(posedge clock);
    #1;
    c = '0; c.mdata = 32'hCAFEF00D; c.mdr_read = 1'b1; c.mdr_in = 1'b1; c.inc_pc = 1'b1;
    c.r_out[3] = 1'b1; c.y_in = 1'b1; c.r_in[2] = 1'b1;
    drive(c);
    #1 clear = 1'b1;
    #1 check_all_zero("clear now");
    @(negedge clock);
    #1 check_all_zero("clear held");
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    #1;
    check("resume mdr", dut.mdr, 32'hCAFEF00D);
    check("resume pc",  dut.pc,  32'h1);
    check("resume y",   dut.y,   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
